// File: rtl/move_sequencer.sv
// Score 4 game-flow controller: cursor moves, disc drop, 4-direction win scan, turn hand-over.
// Latency: cursor move 1 cycle; drop = ROWS FIND + 1 PLACE + 4 CHECK cycles after the drop edge.
// Backpressure: buttons are ignored while busy or game over (dropped, never queued).
// Optional feature: define DRAW_DETECT_EN to end the game as a draw (winner=11) on a full board.
module move_sequencer #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_drop,
  input  logic                     new_game,
  input  logic [COLS*ROWS*2-1:0]   panel,
  input  logic [COLS-1:0]          play,
  input  logic                     turn,
  output logic [COLS*ROWS*2-1:0]   panel_out,
  output logic [COLS-1:0]          play_out,
  output logic                     turn_out,
  output logic                     busy,
  output logic                     game_over,
  output logic [1:0]               winner
);

  localparam int PW = COLS * ROWS * 2;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int NW = $clog2(ROWS + COLS);

  localparam logic [COLS-1:0] PLAY_HOME = {{(COLS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIND  = 3'd1,
    S_PLACE = 3'd2,
    S_CHECK = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;          // column being played
  logic [RW-1:0]  scan_q, scan_d;        // row currently examined in FIND
  logic [RW-1:0]  row_q, row_d;          // lowest free row found in FIND
  logic           found_q, found_d;      // a free row has been latched
  logic [1:0]     dir_q, dir_d;          // CHECK direction: 0 -, 1 |, 2 \, 3 /
  logic [1:0]     winner_q, winner_d;
  logic           game_over_q, game_over_d;

  logic [CW-1:0]  cur_col;
  logic [1:0]     disc_colour;
  logic [NW-1:0]  run_len;
  logic           is_win;
  logic           is_draw;

  // Two bits per cell; column-major with column 0 in the least significant bits.
  function automatic logic [1:0] cell_at(input logic [PW-1:0] p, input int c, input int r);
    return p[(c * ROWS + r) * 2 +: 2];
  endfunction

  assign disc_colour = turn ? 2'b10 : 2'b01;

  // Decode the one-hot cursor into a column index.
  always_comb begin
    cur_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (play[i]) cur_col = CW'(i);
    end
  end

  // Same-colour run through the placed disc along the current CHECK direction, both senses.
  always_comb begin
    int   dc;
    int   dr;
    int   cc;
    int   rr;
    logic going;
    case (dir_q)
      2'd0:    begin dc = 1; dr = 0;  end
      2'd1:    begin dc = 0; dr = 1;  end
      2'd2:    begin dc = 1; dr = 1;  end
      default: begin dc = 1; dr = -1; end
    endcase
    run_len = NW'(1);
    going   = 1'b1;
    for (int k = 1; k < COLS + ROWS; k++) begin
      cc = int'(col_q) + k * dc;
      rr = int'(row_q) + k * dr;
      if (going && cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) begin
        if (cell_at(panel, cc, rr) == disc_colour) run_len = run_len + NW'(1);
        else going = 1'b0;
      end else begin
        going = 1'b0;
      end
    end
    going = 1'b1;
    for (int k = 1; k < COLS + ROWS; k++) begin
      cc = int'(col_q) - k * dc;
      rr = int'(row_q) - k * dr;
      if (going && cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) begin
        if (cell_at(panel, cc, rr) == disc_colour) run_len = run_len + NW'(1);
        else going = 1'b0;
      end else begin
        going = 1'b0;
      end
    end
  end

  assign is_win = (run_len >= NW'(WIN_LEN));

`ifdef DRAW_DETECT_EN
  logic top_full;

  // The board is full exactly when every top cell is occupied.
  always_comb begin
    top_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cell_at(panel, c, 0) == 2'b00) top_full = 1'b0;
    end
  end

  assign is_draw = top_full;
`else
  assign is_draw = 1'b0;
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      scan_q      <= '0;
      row_q       <= '0;
      found_q     <= 1'b0;
      dir_q       <= 2'd0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      scan_q      <= scan_d;
      row_q       <= row_d;
      found_q     <= found_d;
      dir_q       <= dir_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    scan_d      = scan_q;
    row_d       = row_q;
    found_d     = found_q;
    dir_d       = dir_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    case (state_q)
      S_IDLE: begin
        // A full column swallows the drop; the cursor does not move either.
        if (btn_drop && cell_at(panel, int'(cur_col), 0) == 2'b00) begin
          col_d   = cur_col;
          scan_d  = RW'(ROWS - 1);
          row_d   = RW'(ROWS - 1);
          found_d = 1'b0;
          state_d = S_FIND;
        end
      end
      S_FIND: begin
        // Scan bottom-up over all rows so the drop latency is fixed; keep the first hole seen.
        if (!found_q && cell_at(panel, int'(col_q), int'(scan_q)) == 2'b00) begin
          row_d   = scan_q;
          found_d = 1'b1;
        end
        if (scan_q == '0) state_d = S_PLACE;
        else              scan_d  = scan_q - RW'(1);
      end
      S_PLACE: begin
        dir_d   = 2'd0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (is_win) begin
          winner_d    = disc_colour;
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else if (dir_q == 2'd3) begin
          if (is_draw) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      S_OVER: begin
        if (new_game) begin
          winner_d    = 2'b00;
          game_over_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: hold the fed-back state unless the current state rewrites it; reset forces a clear board.
  always_comb begin
    int place_idx;
    panel_out = panel;
    play_out  = play;
    turn_out  = turn;
    busy      = 1'b0;
    winner    = winner_q;
    game_over = game_over_q;
    place_idx = (int'(col_q) * ROWS + int'(row_q)) * 2;
    if (!rst) begin
      panel_out = '0;
      play_out  = PLAY_HOME;
      turn_out  = 1'b0;
      winner    = 2'b00;
      game_over = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!btn_drop) begin
            if (btn_left && !btn_right)      play_out = {play[0], play[COLS-1:1]};
            else if (btn_right && !btn_left) play_out = {play[COLS-2:0], play[COLS-1]};
          end
        end
        S_FIND: busy = 1'b1;
        S_PLACE: begin
          busy = 1'b1;
          panel_out[place_idx +: 2] = disc_colour;
        end
        S_CHECK: begin
          busy = 1'b1;
          if (dir_q == 2'd3 && !is_win && !is_draw) turn_out = ~turn;
        end
        S_OVER: begin
          if (new_game) begin
            panel_out = '0;
            play_out  = PLAY_HOME;
            turn_out  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer; models the board/cursor/turn state registers around it.
// Inputs change and outputs are sampled on the falling clock edge.
// Follows DRAW_DETECT_EN the same way the design does.
module tb_move_sequencer;

  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int PW   = COLS * ROWS * 2;
  localparam int DROP_BUSY = ROWS + 1 + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, new_game = 1'b0;
  logic [PW-1:0] panel_r;
  logic [COLS-1:0] play_r;
  logic          turn_r;
  logic [PW-1:0] panel_out;
  logic [COLS-1:0] play_out;
  logic          turn_out, busy, game_over;
  logic [1:0]    winner;

  logic          ld = 1'b0;
  logic [PW-1:0] ld_panel = '0;
  logic [COLS-1:0] ld_play = '0;
  logic          ld_turn = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  move_sequencer #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop), .new_game(new_game),
    .panel(panel_r), .play(play_r), .turn(turn_r),
    .panel_out(panel_out), .play_out(play_out), .turn_out(turn_out),
    .busy(busy), .game_over(game_over), .winner(winner)
  );

  // External state registers; the loader lets the bench preset a board position.
  always @(posedge clk) begin
    if (ld) begin
      panel_r <= ld_panel;
      play_r  <= ld_play;
      turn_r  <= ld_turn;
    end else begin
      panel_r <= panel_out;
      play_r  <= play_out;
      turn_r  <= turn_out;
    end
  end

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] put(input logic [PW-1:0] p, input int c, input int r,
                                        input logic [1:0] v);
    p[(c * ROWS + r) * 2 +: 2] = v;
    return p;
  endfunction

  function automatic logic [1:0] get(input logic [PW-1:0] p, input int c, input int r);
    return p[(c * ROWS + r) * 2 +: 2];
  endfunction

  task automatic load(input logic [PW-1:0] p, input logic [COLS-1:0] pl, input logic t);
    ld_panel = p; ld_play = pl; ld_turn = t; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic pulse(input bit l, input bit r, input bit ng);
    btn_left = l; btn_right = r; new_game = ng;
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; new_game = 1'b0;
  endtask

  // Pulses drop, then counts falling edges with busy high; flags any turn change while busy.
  task automatic drop_wait(output int nbusy, output bit turn_moved);
    logic t0;
    t0 = turn_r;
    turn_moved = 1'b0;
    btn_drop = 1'b1;
    @(negedge clk);
    btn_drop = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 40) begin
      if (turn_r !== t0) turn_moved = 1'b1;
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] p;
    logic [PW-1:0] exp_p;
    int nb;
    bit tm;

    // ---- reset held two cycles ----
    @(negedge clk);
    @(negedge clk);
    chk_eq("rst_panel_out", 128'(panel_out), 128'(0));
    chk_eq("rst_play_out", 128'(play_out), 128'(7'b0000001));
    chk_eq("rst_turn_out", 128'(turn_out), 128'(0));
    chk_eq("rst_winner", 128'(winner), 128'(0));
    chk_eq("rst_busy", 128'(busy), 128'(0));
    chk_eq("rst_panel_reg", 128'(panel_r), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_play", 128'(play_r), 128'(7'b0000001));

    // ---- cursor ----
    pulse(1, 0, 0);
    chk_eq("left_wrap", 128'(play_r), 128'(7'b1000000));
    pulse(0, 1, 0);
    chk_eq("right_wrap", 128'(play_r), 128'(7'b0000001));
    pulse(1, 1, 0);
    chk_eq("left_right_both", 128'(play_r), 128'(7'b0000001));

    // ---- drop into empty column 3 ----
    load('0, 7'b0001000, 1'b0);
    drop_wait(nb, tm);
    chk_eq("empty_busy_cycles", 128'(nb), 128'(DROP_BUSY));
    chk_eq("empty_turn_held", 128'(tm), 128'(0));
    chk_eq("empty_cell_3_5", 128'(get(panel_r, 3, 5)), 128'(2'b01));
    chk_eq("empty_panel", 128'(panel_r), 128'(put('0, 3, 5, 2'b01)));
    chk_eq("empty_turn_flip", 128'(turn_r), 128'(1));

    // ---- stacking ----
    p = put(put('0, 3, 5, 2'b01), 3, 4, 2'b10);
    load(p, 7'b0001000, 1'b0);
    drop_wait(nb, tm);
    chk_eq("stack_busy_cycles", 128'(nb), 128'(DROP_BUSY));
    chk_eq("stack_cell_3_3", 128'(get(panel_r, 3, 3)), 128'(2'b01));
    chk_eq("stack_panel", 128'(panel_r), 128'(put(p, 3, 3, 2'b01)));
    chk_eq("stack_turn_flip", 128'(turn_r), 128'(1));

    // ---- full column 0 ----
    p = '0;
    for (int r = 0; r < ROWS; r++) p = put(p, 0, r, (r % 2 == 0) ? 2'b01 : 2'b10);
    load(p, 7'b0000001, 1'b0);
    drop_wait(nb, tm);
    chk_eq("full_col_busy", 128'(nb), 128'(0));
    chk_eq("full_col_panel", 128'(panel_r), 128'(p));
    chk_eq("full_col_turn", 128'(turn_r), 128'(0));

    // ---- diagonal win on / through (4,1) ----
    p = '0;
    p = put(p, 1, 5, 2'b10); p = put(p, 1, 4, 2'b01);
    p = put(p, 2, 5, 2'b10); p = put(p, 2, 4, 2'b10); p = put(p, 2, 3, 2'b01);
    p = put(p, 3, 5, 2'b01); p = put(p, 3, 4, 2'b10); p = put(p, 3, 3, 2'b10); p = put(p, 3, 2, 2'b01);
    p = put(p, 4, 5, 2'b01); p = put(p, 4, 4, 2'b10); p = put(p, 4, 3, 2'b01); p = put(p, 4, 2, 2'b10);
    load(p, 7'b0010000, 1'b0);
    drop_wait(nb, tm);
    exp_p = put(p, 4, 1, 2'b01);
    chk_eq("diag_busy_cycles", 128'(nb), 128'(DROP_BUSY));
    chk_eq("diag_panel", 128'(panel_r), 128'(exp_p));
    chk_eq("diag_winner", 128'(winner), 128'(2'b01));
    chk_eq("diag_game_over", 128'(game_over), 128'(1));
    chk_eq("diag_turn_kept", 128'(turn_r), 128'(0));
    drop_wait(nb, tm);
    chk_eq("over_drop_busy", 128'(nb), 128'(0));
    chk_eq("over_drop_panel", 128'(panel_r), 128'(exp_p));
    chk_eq("over_winner_held", 128'(winner), 128'(2'b01));
    pulse(0, 0, 1);
    chk_eq("newgame_panel", 128'(panel_r), 128'(0));
    chk_eq("newgame_winner", 128'(winner), 128'(0));
    chk_eq("newgame_game_over", 128'(game_over), 128'(0));
    chk_eq("newgame_play", 128'(play_r), 128'(7'b0000001));

    // ---- reset during FIND ----
    load('0, 7'b0000100, 1'b0);
    btn_drop = 1'b1;
    @(negedge clk);
    btn_drop = 1'b0;
    chk_eq("find_busy", 128'(busy), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("midrst_busy", 128'(busy), 128'(0));
    chk_eq("midrst_panel", 128'(panel_r), 128'(0));
    chk_eq("midrst_play", 128'(play_r), 128'(7'b0000001));
    pulse(1, 0, 0);
    chk_eq("midrst_idle_left", 128'(play_r), 128'(7'b1000000));

    // ---- full board: 41 discs with no line, last disc green at (6,0) ----
    p = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!(c == 6 && r == 0)) p = put(p, c, r, ((((c >> 1) + r) & 1) == 1) ? 2'b10 : 2'b01);
    load(p, 7'b1000000, 1'b1);
    drop_wait(nb, tm);
    chk_eq("draw_busy_cycles", 128'(nb), 128'(DROP_BUSY));
    chk_eq("draw_panel", 128'(panel_r), 128'(put(p, 6, 0, 2'b10)));
`ifdef DRAW_DETECT_EN
    chk_eq("draw_winner", 128'(winner), 128'(2'b11));
    chk_eq("draw_game_over", 128'(game_over), 128'(1));
    chk_eq("draw_turn_kept", 128'(turn_r), 128'(1));
`else
    chk_eq("nodraw_winner", 128'(winner), 128'(2'b00));
    chk_eq("nodraw_game_over", 128'(game_over), 128'(0));
    chk_eq("nodraw_turn_flip", 128'(turn_r), 128'(0));
    drop_wait(nb, tm);
    chk_eq("nodraw_drop_ignored", 128'(nb), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
